controller_multicycle: RTL and testbench
========================================

CONTROLLER_MULTICYCLE -- requirements
Module: controller_multicycle

Interface
REQ-001 Parameters: none; all encodings SHALL be fixed as stated below.
REQ-002 clock  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 opcode  input  7  instruction register bits [6:0].
REQ-005 funct3  input  3  instruction bits [14:12].
REQ-006 funct7b5  input  1  instruction bit 30.
REQ-007 zero  input  1  ALU zero flag, current cycle.
REQ-008 mem_ready  input  1  memory completes requested access this cycle.
REQ-009 PC_write, IR_write, reg_write, mem_write, mem_read, adr_src  output  1 each  datapath enables/selects.
REQ-010 result_src, ALU_src_A, ALU_src_B, imm_src  output  2 each  mux selects.
REQ-011 ALU_control  output  3  ALU operation.
REQ-012 halted  output  1  high while in HALT.

Function
REQ-013 Moore FSM, 4-bit state; encodings: FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECUTER 6, ALUWB 7, EXECUTEI 8, JAL 9, BEQ 10, HALT 11, JALR_ADR 12, JALR 13.
REQ-014 Outputs SHALL be 0 in every state unless listed; ALU_op (internal, 2 bits) defaults 00.
REQ-015 FETCH: mem_read=1, adr_src=0, ALU_src_A=00, ALU_src_B=10, result_src=10; IR_write=PC_write=mem_ready; stay until mem_ready, then DECODE.
REQ-016 DECODE: ALU_src_A=01, ALU_src_B=01 (branch target into ALUOut); next: 0000011/0100011 -> MEMADR, 0110011 -> EXECUTER, 0010011 -> EXECUTEI, 1101111 -> JAL, 1100011 -> BEQ, 1100111 -> JALR_ADR (macro only), any other -> HALT.
REQ-017 MEMADR: ALU_src_A=10, ALU_src_B=01; opcode[5]=0 -> MEMREAD, else MEMWRITE.
REQ-018 MEMREAD: mem_read=1, adr_src=1; stay until mem_ready, then MEMWB. MEMWB: result_src=01, reg_write=1 -> FETCH.
REQ-019 MEMWRITE: mem_write=1, adr_src=1; stay until mem_ready, then FETCH; mem_write SHALL stay high across wait cycles.
REQ-020 EXECUTER: ALU_src_A=10, ALU_src_B=00, ALU_op=10 -> ALUWB. EXECUTEI: ALU_src_A=10, ALU_src_B=01, ALU_op=10 -> ALUWB.
REQ-021 ALUWB: result_src=00, reg_write=1 -> FETCH.
REQ-022 JAL: ALU_src_A=01, ALU_src_B=10, result_src=00, PC_write=1 -> ALUWB (rd gets oldPC+4).
REQ-023 BEQ: ALU_src_A=10, ALU_src_B=00, ALU_op=01, result_src=00, PC_write=zero -> FETCH.
REQ-024 HALT: halted=1, all enables 0; stays until reset.
REQ-025 imm_src (combinational on opcode): 0100011 -> 01, 1100011 -> 10, 1101111 -> 11, else 00.
REQ-026 ALU_control: ALU_op 00 -> 000; 01 -> 001; 10 by funct3: 000 -> 001 if opcode[5]&funct7b5 else 000, 010 -> 101, 110 -> 011, 111 -> 010, other -> 000.
REQ-027 mem_ready SHALL be ignored outside FETCH/MEMREAD/MEMWRITE.

Reset
REQ-028 reset high at an edge SHALL load FETCH, abandoning any pending memory wait or instruction.
REQ-029 While reset is high, PC_write, IR_write, reg_write, mem_write SHALL be forced 0; other outputs follow FETCH.

Configuration
REQ-030 Macro CONTROLLER_JALR_EN: defined -> JALR_ADR (ALU_src_A=10, ALU_src_B=01, imm_src=00) -> JALR (ALU_src_A=01, ALU_src_B=10, result_src=00, PC_write=1) -> ALUWB; undefined -> opcode 1100111 goes to HALT and states 12/13 are absent.

Verification
REQ-031 reset, then add (0110011, funct3 000, funct7b5 0), mem_ready=1 -> FETCH,DECODE,EXECUTER,ALUWB; ALU_control 000; reg_write=1 only in ALUWB; 4 cycles.
REQ-032 lw with mem_ready low 3 cycles in MEMREAD -> mem_read/adr_src held 3 extra cycles; MEMWB result_src=01; 5+3 cycles.
REQ-033 beq with zero=1 then zero=0 -> PC_write=1 in BEQ first case, 0 second; ALU_control 001.
REQ-034 opcode 1111111 -> HALT, halted=1 for 20 cycles; reset -> FETCH next edge, halted=0.
REQ-035 reset asserted in MEMWRITE wait -> next state FETCH, mem_write=0 that cycle.
REQ-036 jalr (1100111) with macro -> 13 then ALUWB, PC_write=1 in JALR; without -> HALT.

Source files
------------

// File: rtl/controller_multicycle.sv
// controller_multicycle: Moore-style multicycle control FSM for a small RISC-V datapath.
//
// Build option: define CONTROLLER_JALR_EN to add the JALR_ADR/JALR states (opcode 1100111).
//   Without it, jalr is an unknown opcode and the controller halts.
//
// Ports:
//   clock, reset        single clock, synchronous active-high reset
//   opcode/funct3/      instruction fields from the instruction register
//   funct7b5
//   zero                ALU zero flag (branch decision)
//   mem_ready           memory completes the requested access this cycle
//   PC_write, IR_write, reg_write, mem_write, mem_read, adr_src   datapath enables/selects
//   result_src, ALU_src_A, ALU_src_B, imm_src                     2-bit mux selects
//   ALU_control         3-bit ALU operation
//   halted              high while in HALT
module controller_multicycle (
    input  logic       clock,
    input  logic       reset,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       PC_write,
    output logic       IR_write,
    output logic       reg_write,
    output logic       mem_write,
    output logic       mem_read,
    output logic       adr_src,
    output logic [1:0] result_src,
    output logic [1:0] ALU_src_A,
    output logic [1:0] ALU_src_B,
    output logic [1:0] imm_src,
    output logic [2:0] ALU_control,
    output logic       halted
);

    typedef enum logic [3:0] {
        StFetch    = 4'd0,
        StDecode   = 4'd1,
        StMemAdr   = 4'd2,
        StMemRead  = 4'd3,
        StMemWb    = 4'd4,
        StMemWrite = 4'd5,
        StExecuteR = 4'd6,
        StAluWb    = 4'd7,
        StExecuteI = 4'd8,
        StJal      = 4'd9,
        StBeq      = 4'd10,
`ifdef CONTROLLER_JALR_EN
        StHalt     = 4'd11,
        StJalrAdr  = 4'd12,
        StJalr     = 4'd13
`else
        StHalt     = 4'd11
`endif
    } state_e;

    state_e     state_q;
    state_e     state_d;
    state_e     out_state;
    logic [1:0] alu_op;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= StFetch;
        end else begin
            state_q <= state_d;
        end
    end

    // While reset is held the outputs look like FETCH (with write enables
    // suppressed below), regardless of where the state register currently is.
    assign out_state = reset ? StFetch : state_q;

    always_comb begin
        state_d    = state_q;
        PC_write   = 1'b0;
        IR_write   = 1'b0;
        reg_write  = 1'b0;
        mem_write  = 1'b0;
        mem_read   = 1'b0;
        adr_src    = 1'b0;
        result_src = 2'b00;
        ALU_src_A  = 2'b00;
        ALU_src_B  = 2'b00;
        alu_op     = 2'b00;
        halted     = 1'b0;

        unique case (state_q)
            StFetch:    if (mem_ready) state_d = StDecode;
            StDecode: begin
                unique case (opcode)
                    7'b0000011, 7'b0100011: state_d = StMemAdr;
                    7'b0110011:             state_d = StExecuteR;
                    7'b0010011:             state_d = StExecuteI;
                    7'b1101111:             state_d = StJal;
                    7'b1100011:             state_d = StBeq;
`ifdef CONTROLLER_JALR_EN
                    7'b1100111:             state_d = StJalrAdr;
`endif
                    default:                state_d = StHalt;
                endcase
            end
            StMemAdr:   state_d = opcode[5] ? StMemWrite : StMemRead;
            StMemRead:  if (mem_ready) state_d = StMemWb;
            StMemWb:    state_d = StFetch;
            StMemWrite: if (mem_ready) state_d = StFetch;
            StExecuteR: state_d = StAluWb;
            StAluWb:    state_d = StFetch;
            StExecuteI: state_d = StAluWb;
            StJal:      state_d = StAluWb;
            StBeq:      state_d = StFetch;
            StHalt:     state_d = StHalt;
`ifdef CONTROLLER_JALR_EN
            StJalrAdr:  state_d = StJalr;
            StJalr:     state_d = StAluWb;
`endif
            default:    state_d = StHalt;
        endcase

        unique case (out_state)
            StFetch: begin
                mem_read   = 1'b1;
                ALU_src_B  = 2'b10;
                result_src = 2'b10;
                IR_write   = mem_ready;
                PC_write   = mem_ready;
            end
            StDecode: begin
                // Branch target (oldPC + imm) is parked in ALUOut here.
                ALU_src_A = 2'b01;
                ALU_src_B = 2'b01;
            end
            StMemAdr: begin
                ALU_src_A = 2'b10;
                ALU_src_B = 2'b01;
            end
            StMemRead: begin
                mem_read = 1'b1;
                adr_src  = 1'b1;
            end
            StMemWb: begin
                result_src = 2'b01;
                reg_write  = 1'b1;
            end
            StMemWrite: begin
                // Held for the whole wait so the memory sees a stable request.
                mem_write = 1'b1;
                adr_src   = 1'b1;
            end
            StExecuteR: begin
                ALU_src_A = 2'b10;
                alu_op    = 2'b10;
            end
            StAluWb: begin
                reg_write = 1'b1;
            end
            StExecuteI: begin
                ALU_src_A = 2'b10;
                ALU_src_B = 2'b01;
                alu_op    = 2'b10;
            end
            StJal: begin
                // PC <= branch target from ALUOut; ALU computes oldPC+4 for rd.
                ALU_src_A = 2'b01;
                ALU_src_B = 2'b10;
                PC_write  = 1'b1;
            end
            StBeq: begin
                ALU_src_A = 2'b10;
                alu_op    = 2'b01;
                PC_write  = zero;
            end
            StHalt: begin
                halted = 1'b1;
            end
`ifdef CONTROLLER_JALR_EN
            StJalrAdr: begin
                ALU_src_A = 2'b10;
                ALU_src_B = 2'b01;
            end
            StJalr: begin
                ALU_src_A = 2'b01;
                ALU_src_B = 2'b10;
                PC_write  = 1'b1;
            end
`endif
            default: begin
                halted = 1'b0;
            end
        endcase

        if (reset) begin
            PC_write  = 1'b0;
            IR_write  = 1'b0;
            reg_write = 1'b0;
            mem_write = 1'b0;
        end
    end

    always_comb begin
        unique case (opcode)
            7'b0100011: imm_src = 2'b01;
            7'b1100011: imm_src = 2'b10;
            7'b1101111: imm_src = 2'b11;
            default:    imm_src = 2'b00;
        endcase
    end

    always_comb begin
        ALU_control = 3'b000;
        unique case (alu_op)
            2'b01: ALU_control = 3'b001;
            2'b10: begin
                unique case (funct3)
                    // Only R-type (opcode[5]=1) can select subtract.
                    3'b000:  ALU_control = (opcode[5] & funct7b5) ? 3'b001 : 3'b000;
                    3'b010:  ALU_control = 3'b101;
                    3'b110:  ALU_control = 3'b011;
                    3'b111:  ALU_control = 3'b010;
                    default: ALU_control = 3'b000;
                endcase
            end
            default: ALU_control = 3'b000;
        endcase
    end

endmodule

// File: tb/tb_controller_multicycle.sv
module tb_controller_multicycle;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [6:0] opcode = 7'b0110011;
    logic [2:0] funct3 = 3'b000;
    logic       funct7b5 = 1'b0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic       PC_write, IR_write, reg_write, mem_write, mem_read, adr_src;
    logic [1:0] result_src, ALU_src_A, ALU_src_B, imm_src;
    logic [2:0] ALU_control;
    logic       halted;

    int checks = 0;
    int errors = 0;

    localparam logic [3:0] SFetch = 4'd0, SDecode = 4'd1, SMemAdr = 4'd2, SMemRead = 4'd3,
        SMemWb = 4'd4, SMemWrite = 4'd5, SExecR = 4'd6, SAluWb = 4'd7, SExecI = 4'd8,
        SJal = 4'd9, SBeq = 4'd10, SHalt = 4'd11, SJalrAdr = 4'd12, SJalr = 4'd13,
        SAny = 4'd15;

    controller_multicycle dut (
        .clock      (clock),
        .reset      (reset),
        .opcode     (opcode),
        .funct3     (funct3),
        .funct7b5   (funct7b5),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .PC_write   (PC_write),
        .IR_write   (IR_write),
        .reg_write  (reg_write),
        .mem_write  (mem_write),
        .mem_read   (mem_read),
        .adr_src    (adr_src),
        .result_src (result_src),
        .ALU_src_A  (ALU_src_A),
        .ALU_src_B  (ALU_src_B),
        .imm_src    (imm_src),
        .ALU_control(ALU_control),
        .halted     (halted)
    );

    always #5 clock = ~clock;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    // Scoreboard entry: inputs to apply for one cycle plus the state and outputs
    // expected during that cycle.
    typedef struct {
        logic        rst;
        logic        mr;
        logic        z;
        logic [3:0]  st;
        logic [17:0] outs;
        string       name;
    } entry_t;

    entry_t sb_q[$];

    function automatic logic [17:0] mk(input logic pcw, irw, rw, mw, mr, as,
                                       input logic [1:0] rs, sa, sb, imm,
                                       input logic [2:0] aluc, input logic h);
        return {pcw, irw, rw, mw, mr, as, rs, sa, sb, imm, aluc, h};
    endfunction

    function automatic logic [17:0] e_fetch(input logic mr, input logic [1:0] imm);
        return mk(mr, mr, 1'b0, 1'b0, 1'b1, 1'b0, 2'b10, 2'b00, 2'b10, imm, 3'b000, 1'b0);
    endfunction

    function automatic logic [17:0] e_decode(input logic [1:0] imm);
        return mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b01, imm, 3'b000, 1'b0);
    endfunction

    function automatic logic [17:0] e_rst(input logic [1:0] imm);
        return mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b10, 2'b00, 2'b10, imm, 3'b000, 1'b0);
    endfunction

    function automatic logic [17:0] e_aluwb(input logic [1:0] imm);
        return mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, imm, 3'b000, 1'b0);
    endfunction

    task automatic push(input string name, input logic rst, mr, z, input logic [3:0] st,
                        input logic [17:0] outs);
        entry_t e;
        e.rst = rst; e.mr = mr; e.z = z; e.st = st; e.outs = outs; e.name = name;
        sb_q.push_back(e);
    endtask

    // Drives each queued cycle's inputs, compares mid-cycle, then advances one edge.
    task automatic run_queue();
        entry_t      e;
        logic [17:0] obs;
        logic [3:0]  st;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            reset = e.rst;
            mem_ready = e.mr;
            zero = e.z;
            @(negedge clock);
            st = 4'(dut.state_q);
            obs = {PC_write, IR_write, reg_write, mem_write, mem_read, adr_src, result_src,
                   ALU_src_A, ALU_src_B, imm_src, ALU_control, halted};
            if (e.st != SAny) begin
                checks++;
                if (st !== e.st) begin
                    errors++;
                    $display("FAIL %s state: got %0d required %0d", e.name, st, e.st);
                end
            end
            checks++;
            if (obs !== e.outs) begin
                errors++;
                $display("FAIL %s outputs: got %b required %b", e.name, obs, e.outs);
            end
            @(posedge clock);
            #1;
        end
    endtask

    function automatic logic rnd();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic test_reset();
        opcode = 7'b0110011; funct3 = 3'b000; funct7b5 = 1'b0;
        push("reset0", 1'b1, 1'b1, 1'b0, SAny, e_rst(2'b00));
        push("reset1", 1'b1, 1'b1, 1'b0, SFetch, e_rst(2'b00));
        push("reset2", 1'b1, 1'b0, 1'b0, SFetch, e_rst(2'b00));
        push("reset_rel", 1'b0, 1'b0, 1'b0, SFetch, e_fetch(1'b0, 2'b00));
        run_queue();
    endtask

    task automatic test_rtype(input logic f7, input logic [2:0] aluc, input string name);
        opcode = 7'b0110011; funct3 = 3'b000; funct7b5 = f7;
        push({name, "_fetch"}, 1'b0, 1'b1, 1'b0, SFetch, e_fetch(1'b1, 2'b00));
        push({name, "_decode"}, 1'b0, rnd(), 1'b0, SDecode, e_decode(2'b00));
        push({name, "_execr"}, 1'b0, rnd(), 1'b0, SExecR,
             mk(0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b00, aluc, 0));
        push({name, "_aluwb"}, 1'b0, rnd(), 1'b0, SAluWb, e_aluwb(2'b00));
        push({name, "_back"}, 1'b0, 1'b0, 1'b0, SFetch, e_fetch(1'b0, 2'b00));
        run_queue();
    endtask

    task automatic test_itype();
        logic [2:0] f3_tab[5]   = '{3'b000, 3'b010, 3'b110, 3'b111, 3'b100};
        logic       f7_tab[5]   = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        logic [2:0] aluc_tab[5] = '{3'b000, 3'b101, 3'b011, 3'b010, 3'b000};
        opcode = 7'b0010011;
        for (int i = 0; i < 5; i++) begin
            funct3 = f3_tab[i]; funct7b5 = f7_tab[i];
            push("itype_fetch", 1'b0, 1'b1, 1'b0, SFetch, e_fetch(1'b1, 2'b00));
            push("itype_decode", 1'b0, rnd(), 1'b0, SDecode, e_decode(2'b00));
            push("itype_exec", 1'b0, rnd(), 1'b0, SExecI,
                 mk(0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, aluc_tab[i], 0));
            push("itype_aluwb", 1'b0, rnd(), 1'b0, SAluWb, e_aluwb(2'b00));
            run_queue();
        end
    endtask

    task automatic test_lw_wait();
        opcode = 7'b0000011; funct3 = 3'b010; funct7b5 = 1'b0;
        push("lw_fetch", 1'b0, 1'b1, 1'b0, SFetch, e_fetch(1'b1, 2'b00));
        push("lw_decode", 1'b0, rnd(), 1'b0, SDecode, e_decode(2'b00));
        push("lw_memadr", 1'b0, rnd(), 1'b0, SMemAdr,
             mk(0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, 3'b000, 0));
        for (int i = 0; i < 4; i++) begin
            push("lw_memread", 1'b0, (i == 3), 1'b0, SMemRead,
                 mk(0, 0, 0, 0, 1, 1, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 0));
        end
        push("lw_memwb", 1'b0, rnd(), 1'b0, SMemWb,
             mk(0, 0, 1, 0, 0, 0, 2'b01, 2'b00, 2'b00, 2'b00, 3'b000, 0));
        push("lw_back", 1'b0, 1'b0, 1'b0, SFetch, e_fetch(1'b0, 2'b00));
        run_queue();
    endtask

    task automatic test_sw(input logic do_reset);
        logic [17:0] memw = mk(0, 0, 0, 1, 0, 1, 2'b00, 2'b00, 2'b00, 2'b01, 3'b000, 0);
        opcode = 7'b0100011; funct3 = 3'b010; funct7b5 = 1'b0;
        push("sw_fetch_wait", 1'b0, 1'b0, 1'b0, SFetch, e_fetch(1'b0, 2'b01));
        push("sw_fetch", 1'b0, 1'b1, 1'b0, SFetch, e_fetch(1'b1, 2'b01));
        push("sw_decode", 1'b0, rnd(), 1'b0, SDecode, e_decode(2'b01));
        push("sw_memadr", 1'b0, rnd(), 1'b0, SMemAdr,
             mk(0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b01, 3'b000, 0));
        push("sw_memwrite_w0", 1'b0, 1'b0, 1'b0, SMemWrite, memw);
        if (do_reset) begin
            push("sw_reset_in_wait", 1'b1, 1'b0, 1'b0, SMemWrite, e_rst(2'b01));
        end else begin
            push("sw_memwrite_w1", 1'b0, 1'b0, 1'b0, SMemWrite, memw);
            push("sw_memwrite_done", 1'b0, 1'b1, 1'b0, SMemWrite, memw);
        end
        push("sw_back", 1'b0, 1'b0, 1'b0, SFetch, e_fetch(1'b0, 2'b01));
        run_queue();
    endtask

    task automatic test_beq(input logic z);
        opcode = 7'b1100011; funct3 = 3'b000; funct7b5 = 1'b0;
        push("beq_fetch", 1'b0, 1'b1, 1'b0, SFetch, e_fetch(1'b1, 2'b10));
        push("beq_decode", 1'b0, rnd(), 1'b0, SDecode, e_decode(2'b10));
        push("beq_exec", 1'b0, rnd(), z, SBeq,
             mk(z, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b10, 3'b001, 0));
        push("beq_back", 1'b0, 1'b0, 1'b0, SFetch, e_fetch(1'b0, 2'b10));
        run_queue();
    endtask

    task automatic test_jal();
        opcode = 7'b1101111; funct3 = 3'b000; funct7b5 = 1'b0;
        push("jal_fetch", 1'b0, 1'b1, 1'b0, SFetch, e_fetch(1'b1, 2'b11));
        push("jal_decode", 1'b0, rnd(), 1'b0, SDecode, e_decode(2'b11));
        push("jal_exec", 1'b0, rnd(), 1'b0, SJal,
             mk(1, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10, 2'b11, 3'b000, 0));
        push("jal_aluwb", 1'b0, rnd(), 1'b0, SAluWb, e_aluwb(2'b11));
        push("jal_back", 1'b0, 1'b0, 1'b0, SFetch, e_fetch(1'b0, 2'b11));
        run_queue();
    endtask

    task automatic test_halt(input logic [6:0] op, input string name);
        logic [17:0] h = mk(0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 1);
        opcode = op; funct3 = 3'b000; funct7b5 = 1'b0;
        push({name, "_fetch"}, 1'b0, 1'b1, 1'b0, SFetch, e_fetch(1'b1, 2'b00));
        push({name, "_decode"}, 1'b0, rnd(), 1'b0, SDecode, e_decode(2'b00));
        for (int i = 0; i < 20; i++) begin
            push({name, "_halt"}, 1'b0, rnd(), rnd(), SHalt, h);
        end
        push({name, "_reset"}, 1'b1, 1'b0, 1'b0, SHalt, e_rst(2'b00));
        push({name, "_after"}, 1'b0, 1'b0, 1'b0, SFetch, e_fetch(1'b0, 2'b00));
        run_queue();
    endtask

    task automatic test_jalr();
`ifdef CONTROLLER_JALR_EN
        opcode = 7'b1100111; funct3 = 3'b000; funct7b5 = 1'b0;
        push("jalr_fetch", 1'b0, 1'b1, 1'b0, SFetch, e_fetch(1'b1, 2'b00));
        push("jalr_decode", 1'b0, rnd(), 1'b0, SDecode, e_decode(2'b00));
        push("jalr_adr", 1'b0, rnd(), 1'b0, SJalrAdr,
             mk(0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, 3'b000, 0));
        push("jalr_exec", 1'b0, rnd(), 1'b0, SJalr,
             mk(1, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10, 2'b00, 3'b000, 0));
        push("jalr_aluwb", 1'b0, rnd(), 1'b0, SAluWb, e_aluwb(2'b00));
        push("jalr_back", 1'b0, 1'b0, 1'b0, SFetch, e_fetch(1'b0, 2'b00));
        run_queue();
`else
        test_halt(7'b1100111, "jalr_off");
`endif
    endtask

    initial begin
        @(posedge clock);
        #1;
        test_reset();
        test_rtype(1'b0, 3'b000, "add");
        test_rtype(1'b1, 3'b001, "sub");
        test_itype();
        test_lw_wait();
        test_sw(1'b0);
        test_beq(1'b1);
        test_beq(1'b0);
        test_jal();
        test_jalr();
        test_sw(1'b1);
        test_halt(7'b1111111, "illegal");
        test_rtype(1'b0, 3'b000, "add_after_halt");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
